// File: rtl/mem_req_arbiter_if.sv
// Bundle of requester-side and wrapper-side signals for mem_req_arbiter.
// master = the arbiter itself; slave = the requesters and mem_ctrl_wrapper around it.
interface mem_req_arbiter_if #(
   parameter int unsigned NUM_REQ_BITS = 1,
   parameter int unsigned REQ_ID_BITS  = 3,
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned LINE_WIDTH   = 32
);
   localparam int unsigned NUM_REQ  = 1 << NUM_REQ_BITS;
   localparam int unsigned ID_WIDTH = NUM_REQ_BITS + REQ_ID_BITS;

   // requester side
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_rw;
   logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
   logic [NUM_REQ*LINE_WIDTH-1:0] req_data;
   logic [NUM_REQ*REQ_ID_BITS-1:0] req_id;
   logic [NUM_REQ-1:0]            req_ack;
   logic [NUM_REQ-1:0]            rsp_valid;
   logic [REQ_ID_BITS-1:0]        rsp_id;
   logic [LINE_WIDTH-1:0]         rsp_data;

   // wrapper side
   logic                          mem_valid;
   logic                          mem_rw;
   logic [ADDR_WIDTH-1:0]         mem_addr;
   logic [LINE_WIDTH-1:0]         mem_data;
   logic [ID_WIDTH-1:0]           mem_id;
   logic                          mem_stall;
   logic                          mem_ready;
   logic [ID_WIDTH-1:0]           mem_rid;
   logic [LINE_WIDTH-1:0]         mem_rdata;

   modport master (
      input  req_valid, req_rw, req_addr, req_data, req_id,
      input  mem_stall, mem_ready, mem_rid, mem_rdata,
      output req_ack, rsp_valid, rsp_id, rsp_data,
      output mem_valid, mem_rw, mem_addr, mem_data, mem_id
   );

   modport slave (
      output req_valid, req_rw, req_addr, req_data, req_id,
      output mem_stall, mem_ready, mem_rid, mem_rdata,
      input  req_ack, rsp_valid, rsp_id, rsp_data,
      input  mem_valid, mem_rw, mem_addr, mem_data, mem_id
   );
endinterface

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing one mem_ctrl_wrapper request port among NUM_REQ requesters,
// with a one-entry registered output stage, tag-based response decode and per-requester read caps.
module mem_req_arbiter #(
   parameter int unsigned NUM_REQ_BITS = 1,
   parameter int unsigned REQ_ID_BITS  = 3,
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned LINE_WIDTH   = 32,
   parameter int unsigned MAX_OUTST    = 2
) (
   input logic              clk,
   input logic              reset,
   mem_req_arbiter_if.master bus
);
   localparam int unsigned NUM_REQ   = 1 << NUM_REQ_BITS;
   localparam int unsigned ID_WIDTH  = NUM_REQ_BITS + REQ_ID_BITS;
   localparam int unsigned CNT_WIDTH = $clog2(MAX_OUTST + 1);

   typedef logic [NUM_REQ_BITS-1:0] req_idx_t;
   typedef logic [CNT_WIDTH-1:0]    cnt_t;

   logic [ADDR_WIDTH-1:0]  addr_slice [NUM_REQ];
   logic [LINE_WIDTH-1:0]  data_slice [NUM_REQ];
   logic [REQ_ID_BITS-1:0] id_slice   [NUM_REQ];

   cnt_t               outst_cnt [NUM_REQ];
   logic [NUM_REQ-1:0] eligible;
   logic [NUM_REQ-1:0] cnt_inc;
   logic [NUM_REQ-1:0] cnt_dec;
   req_idx_t           rr_ptr;
   req_idx_t           grant_idx;
   req_idx_t           rsp_owner;
   logic               grant_found;
   logic               stage_open;

   // Unpack the flat per-requester buses into indexable arrays.
   for (genvar k = 0; k < NUM_REQ; k++) begin : g_slice
      assign addr_slice[k] = bus.req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
      assign data_slice[k] = bus.req_data[k*LINE_WIDTH +: LINE_WIDTH];
      assign id_slice[k]   = bus.req_id[k*REQ_ID_BITS +: REQ_ID_BITS];
   end

   assign stage_open = !bus.mem_valid || !bus.mem_stall;
   assign rsp_owner  = bus.mem_rid[ID_WIDTH-1 -: NUM_REQ_BITS];

   // Writes are always eligible; reads only while the requester is under its in-flight cap.
   always_comb begin
      eligible = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         eligible[k] = bus.req_valid[k] && (bus.req_rw[k] || (outst_cnt[k] < cnt_t'(MAX_OUTST)));
      end
   end

   // Round-robin scan starting at rr_ptr; index arithmetic wraps at NUM_REQ_BITS.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!grant_found && eligible[rr_ptr + req_idx_t'(i)]) begin
            grant_found = 1'b1;
            grant_idx   = rr_ptr + req_idx_t'(i);
         end
      end
   end

   // Output stage: holds steady under stall, otherwise reloads or empties every cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.mem_valid <= 1'b0;
         bus.mem_rw    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_data  <= '0;
         bus.mem_id    <= '0;
         bus.req_ack   <= '0;
         rr_ptr        <= '0;
      end else begin
         bus.req_ack <= '0;
         if (stage_open) begin
            if (grant_found) begin
               bus.mem_valid <= 1'b1;
               bus.mem_rw    <= bus.req_rw[grant_idx];
               bus.mem_addr  <= addr_slice[grant_idx];
               bus.mem_data  <= data_slice[grant_idx];
               bus.mem_id    <= {grant_idx, id_slice[grant_idx]};
               bus.req_ack   <= NUM_REQ'(1) << grant_idx;
               rr_ptr        <= grant_idx + req_idx_t'(1);
            end else begin
               bus.mem_valid <= 1'b0;
            end
         end
      end
   end

   // A zero counter ignores responses so stale pre-reset returns cannot underflow it.
   always_comb begin
      cnt_inc = '0;
      cnt_dec = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cnt_inc[k] = stage_open && grant_found && !bus.req_rw[grant_idx]
                      && (grant_idx == req_idx_t'(k));
         cnt_dec[k] = bus.mem_ready && (rsp_owner == req_idx_t'(k))
                      && (outst_cnt[k] != '0);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < NUM_REQ; k++) outst_cnt[k] <= '0;
      end else begin
         for (int k = 0; k < NUM_REQ; k++) begin
            if (cnt_inc[k] && !cnt_dec[k]) begin
               outst_cnt[k] <= outst_cnt[k] + cnt_t'(1);
            end else if (cnt_dec[k] && !cnt_inc[k]) begin
               outst_cnt[k] <= outst_cnt[k] - cnt_t'(1);
            end
         end
      end
   end

   // Zero-latency read return decode by the tag's requester field.
   always_comb begin
      bus.rsp_valid = '0;
      if (bus.mem_ready) bus.rsp_valid[rsp_owner] = 1'b1;
   end

   assign bus.rsp_id   = bus.mem_rid[REQ_ID_BITS-1:0];
   assign bus.rsp_data = bus.mem_rdata;

endmodule
